// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops bytes from a 1-cycle-latency FIFO and sends each as an 8N1 UART frame, LSB first.
module uart_tx_fifo_reader #(
    parameter int   CLKS_PER_BIT = 868,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d, rd_d, busy_d, done_d;
    logic            bit_end;

    assign bit_end = baud_q == LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx         <= IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            fifo_rd_en <= rd_d;
            busy       <= busy_d;
            tx_done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : REQ;
            REQ:     state_d = WAIT;
            WAIT:    state_d = START;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
            STOP:    state_d = bit_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered pins line up with the state they describe.
    always_comb begin
        baud_d  = (state_d != state_q || bit_end || !(state_q inside {START, DATA, STOP})) ? '0 : baud_q + 1'b1;
        bit_d   = (state_d != state_q) ? 3'd0 : (state_q == DATA && bit_end) ? bit_q + 3'd1 : bit_q;
        shift_d = (state_q == WAIT) ? fifo_dout : (state_q == DATA && bit_end) ? {1'b0, shift_q[7:1]} : shift_q;
        tx_d    = (state_d == START) ? ~IDLE_LEVEL : (state_d == DATA) ? shift_d[0] : IDLE_LEVEL;
        rd_d    = state_d == REQ;
        busy_d  = state_d != IDLE;
        done_d  = state_q == STOP && state_d == IDLE;
    end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: directed frame vectors against two instances (4 and 2 clocks per bit) fed by a FIFO model.
module tb_uart_tx_fifo_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       tog_en = 1'b0;
    logic       tog = 1'b0;
    logic [7:0] dout = 8'h00;
    logic [7:0] mem [0:63];
    int         wr_ptr = 0, rd_ptr = 0;
    int         rd_cnt = 0, busy_cnt = 0, cyc = 0, rd_t_last = 0, rd_t_prev = 0;
    int         n_vec = 0, n_err = 0;
    logic       rd1, tx1, busy1, done1, rd2, tx2, busy2, done2;
    logic       empty_m, empty1, empty2, tx_s, busy_s, done_s, rd_s;

    always #5 clk = ~clk;

    assign tx_s    = sel ? tx2 : tx1;
    assign busy_s  = sel ? busy2 : busy1;
    assign done_s  = sel ? done2 : done1;
    assign rd_s    = sel ? rd2 : rd1;
    assign empty_m = (tog_en && busy_s) ? tog : (rd_ptr == wr_ptr);
    assign empty1  = sel ? 1'b1 : empty_m;
    assign empty2  = sel ? empty_m : 1'b1;

    uart_tx_fifo_reader #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_dout(dout),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));

    uart_tx_fifo_reader #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_dout(dout),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

    // FIFO model: data appears on dout the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd1 === 1'b1 || rd2 === 1'b1) begin
            rd_cnt++;
            rd_t_prev = rd_t_last;
            rd_t_last = cyc;
            if (rd_ptr != wr_ptr) begin
                dout <= mem[rd_ptr];
                rd_ptr++;
            end
        end
        if (busy_s === 1'b1) busy_cnt++;
        tog <= ~tog;
        cyc++;
    end

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic [9:0] exp;
        int         cpb;
        logic       tog;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_tx"}, 32'(tx_s), 1);
        chk({nm, "_busy"}, 32'(busy_s), 0);
        chk({nm, "_rd"}, 32'(rd_s), 0);
        chk({nm, "_done"}, 32'(done_s), 0);
    endtask

    task automatic check_frame(input logic [9:0] exp, input int cpb, output int waited);
        waited = 0;
        while (tx_s !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("start_seen", 32'(waited < 2000), 1);
        for (int i = 0; i < 10 * cpb; i++) begin
            chk($sformatf("bit%0d", i / cpb), 32'(tx_s), 32'(exp[i / cpb]));
            @(negedge clk);
        end
        chk("tx_done_hi", 32'(done_s), 1);
        @(negedge clk);
        chk("tx_done_lo", 32'(done_s), 0);
    endtask

    initial begin
        int w, rb, bb, bad_tx, bad_busy;
        // frame pattern: bit i = line level in bit period i (start, d0..d7, stop)
        vt[0] = '{1'b0, 8'hA5, 10'h34A, 4, 1'b0};
        vt[1] = '{1'b0, 8'hC3, 10'h386, 4, 1'b1};
        vt[2] = '{1'b1, 8'hC3, 10'h386, 2, 1'b1};
        vt[3] = '{1'b1, 8'hA5, 10'h34A, 2, 1'b0};

        push(8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            chk_idle($sformatf("reset%0d", i));
        end
        rb = rd_cnt;
        w = 0;
        while (tx1 !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("5a_start", 32'(w), 3);
        repeat (16) @(negedge clk);
        chk("5a_bit3", 32'(tx1), 1);
        chk("5a_busy", 32'(busy1), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midreset");
        chk("5a_pops", 32'(rd_cnt - rb), 1);
        repeat (50) @(negedge clk);
        chk("post_reset_pops", 32'(rd_cnt - rb), 1);
        chk("post_reset_busy", 32'(busy1), 0);
        push(8'h3C);
        check_frame(10'h278, 4, w);

        foreach (vt[i]) begin
            sel = vt[i].sel;
            tog_en = vt[i].tog;
            rb = rd_cnt;
            bb = busy_cnt;
            push(vt[i].data);
            check_frame(vt[i].exp, vt[i].cpb, w);
            tog_en = 1'b0;
            chk($sformatf("vec%0d_pops", i), 32'(rd_cnt - rb), 1);
            chk($sformatf("vec%0d_busy", i), 32'(busy_cnt - bb), 32'(10 * vt[i].cpb + 2));
        end

        sel = 1'b0;
        rb = rd_cnt;
        push(8'h00);
        push(8'hFF);
        check_frame(10'h200, 4, w);
        check_frame(10'h3FE, 4, w);
        chk("b2b_gap", 32'(w), 2);
        chk("b2b_pops", 32'(rd_cnt - rb), 2);
        chk("b2b_spacing", 32'(rd_t_last - rd_t_prev), 43);

        rb = rd_cnt;
        bad_tx = 0;
        bad_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1) bad_tx++;
            if (busy1 !== 1'b0) bad_busy++;
        end
        chk("empty_pops", 32'(rd_cnt - rb), 0);
        chk("empty_tx", 32'(bad_tx), 0);
        chk("empty_busy", 32'(bad_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
